// File: rtl/zr_icb_arb2.sv
// 2:1 round-robin ICB arbiter; an ID FIFO steers in-order responses back to the issuing initiator.
// Latency: zero-cycle combinational command and response paths; only arbitration state and the ID FIFO are flops.
// Backpressure: grant held until the command handshake; commands stall while OUTS_DEPTH transactions are outstanding.
module zr_icb_arb2 #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int OUTS_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_cmd_valid,
    output logic              m0_cmd_ready,
    input  logic [AW-1:0]     m0_cmd_addr,
    input  logic              m0_cmd_read,
    input  logic [DW-1:0]     m0_cmd_wdata,
    input  logic [DW/8-1:0]   m0_cmd_wmask,
    output logic              m0_rsp_valid,
    input  logic              m0_rsp_ready,
    output logic [DW-1:0]     m0_rsp_rdata,
    output logic              m0_rsp_err,
    input  logic              m1_cmd_valid,
    output logic              m1_cmd_ready,
    input  logic [AW-1:0]     m1_cmd_addr,
    input  logic              m1_cmd_read,
    input  logic [DW-1:0]     m1_cmd_wdata,
    input  logic [DW/8-1:0]   m1_cmd_wmask,
    output logic              m1_rsp_valid,
    input  logic              m1_rsp_ready,
    output logic [DW-1:0]     m1_rsp_rdata,
    output logic              m1_rsp_err,
    output logic              s_cmd_valid,
    input  logic              s_cmd_ready,
    output logic [AW-1:0]     s_cmd_addr,
    output logic              s_cmd_read,
    output logic [DW-1:0]     s_cmd_wdata,
    output logic [DW/8-1:0]   s_cmd_wmask,
    input  logic              s_rsp_valid,
    output logic              s_rsp_ready,
    input  logic [DW-1:0]     s_rsp_rdata,
    input  logic              s_rsp_err
);

    localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
    localparam int CW = $clog2(OUTS_DEPTH + 1);

    logic          lock_q, lock_d;
    logic          lock_id_q, lock_id_d;
    logic          prio_q, prio_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          id_mem_q [OUTS_DEPTH];
    logic          id_mem_d [OUTS_DEPTH];

    logic grant;
    logic req;
    logic cmd_rdy;
    logic cmd_hs;
    logic fifo_full;
    logic fifo_empty;
    logic head;
    logic rsp_en;
    logic rsp_hs;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTS_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign fifo_full  = (cnt_q == CW'(OUTS_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign head       = id_mem_q[rd_ptr_q];

    always_comb begin
        grant = 1'b0;
        if (lock_q) begin
            grant = lock_id_q;
        end else if (m0_cmd_valid && m1_cmd_valid) begin
            grant = prio_q;
        end else begin
            grant = m1_cmd_valid;
        end
    end

    // Outputs are gated by rst so nothing handshakes while state is being cleared.
    assign req          = grant ? m1_cmd_valid : m0_cmd_valid;
    assign s_cmd_valid  = ~rst & req & ~fifo_full;
    assign cmd_rdy      = ~rst & s_cmd_ready & ~fifo_full;
    assign m0_cmd_ready = cmd_rdy & ~grant;
    assign m1_cmd_ready = cmd_rdy & grant;
    assign s_cmd_addr   = grant ? m1_cmd_addr  : m0_cmd_addr;
    assign s_cmd_read   = grant ? m1_cmd_read  : m0_cmd_read;
    assign s_cmd_wdata  = grant ? m1_cmd_wdata : m0_cmd_wdata;
    assign s_cmd_wmask  = grant ? m1_cmd_wmask : m0_cmd_wmask;
    assign cmd_hs       = s_cmd_valid & s_cmd_ready;

    assign rsp_en       = ~rst & ~fifo_empty;
    assign m0_rsp_valid = rsp_en & ~head & s_rsp_valid;
    assign m1_rsp_valid = rsp_en & head & s_rsp_valid;
    assign s_rsp_ready  = rsp_en & (head ? m1_rsp_ready : m0_rsp_ready);
    assign m0_rsp_rdata = s_rsp_rdata;
    assign m1_rsp_rdata = s_rsp_rdata;
    assign m0_rsp_err   = s_rsp_err;
    assign m1_rsp_err   = s_rsp_err;
    assign rsp_hs       = s_rsp_valid & s_rsp_ready;

    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        prio_d    = prio_q;
        if (cmd_hs) begin
            lock_d = 1'b0;
            prio_d = ~grant;
        end else if (s_cmd_valid) begin
            lock_d    = 1'b1;
            lock_id_d = grant;
        end
    end

    // cmd_hs already implies the FIFO is not full, and rsp_hs that it is not empty.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        id_mem_d = id_mem_q;
        if (cmd_hs) begin
            id_mem_d[wr_ptr_q] = grant;
            wr_ptr_d           = ptr_inc(wr_ptr_q);
        end
        if (rsp_hs) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({cmd_hs, rsp_hs})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
            prio_q    <= 1'b0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            prio_q    <= prio_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        id_mem_q <= id_mem_d;
    end

endmodule

// File: tb/tb_zr_icb_arb2.sv
// Bench for zr_icb_arb2: command and response scoreboards plus directed checks on arbitration and FIFO edges.
module tb_zr_icb_arb2;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int OD = 2;
    localparam logic [31:0] A_BASE = 32'h1000_0000;
    localparam logic [31:0] B_BASE = 32'h2000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            m0_cmd_valid, m0_cmd_ready, m0_cmd_read;
    logic [AW-1:0]   m0_cmd_addr;
    logic [DW-1:0]   m0_cmd_wdata;
    logic [DW/8-1:0] m0_cmd_wmask;
    logic            m0_rsp_valid, m0_rsp_ready, m0_rsp_err;
    logic [DW-1:0]   m0_rsp_rdata;
    logic            m1_cmd_valid, m1_cmd_ready, m1_cmd_read;
    logic [AW-1:0]   m1_cmd_addr;
    logic [DW-1:0]   m1_cmd_wdata;
    logic [DW/8-1:0] m1_cmd_wmask;
    logic            m1_rsp_valid, m1_rsp_ready, m1_rsp_err;
    logic [DW-1:0]   m1_rsp_rdata;
    logic            s_cmd_valid, s_cmd_ready, s_cmd_read;
    logic [AW-1:0]   s_cmd_addr;
    logic [DW-1:0]   s_cmd_wdata;
    logic [DW/8-1:0] s_cmd_wmask;
    logic            s_rsp_valid, s_rsp_ready, s_rsp_err;
    logic [DW-1:0]   s_rsp_rdata;

    int          m0_left, m1_left;
    int          total = 0;
    int          bad = 0;
    logic        h0, h1, hr;
    bit          tgt_auto;
    bit          drained;
    logic [31:0] cmd_q [$];
    logic [32:0] rsp_q [$];
    logic [31:0] pend [$];

    assign m0_cmd_valid = (m0_left != 0);
    assign m1_cmd_valid = (m1_left != 0);

    zr_icb_arb2 #(.AW(AW), .DW(DW), .OUTS_DEPTH(OD)) dut (
        .clk(clk), .rst(rst),
        .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_addr(m0_cmd_addr),
        .m0_cmd_read(m0_cmd_read), .m0_cmd_wdata(m0_cmd_wdata), .m0_cmd_wmask(m0_cmd_wmask),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready), .m0_rsp_rdata(m0_rsp_rdata),
        .m0_rsp_err(m0_rsp_err),
        .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_addr(m1_cmd_addr),
        .m1_cmd_read(m1_cmd_read), .m1_cmd_wdata(m1_cmd_wdata), .m1_cmd_wmask(m1_cmd_wmask),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready), .m1_rsp_rdata(m1_rsp_rdata),
        .m1_rsp_err(m1_rsp_err),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_addr(s_cmd_addr),
        .s_cmd_read(s_cmd_read), .s_cmd_wdata(s_cmd_wdata), .s_cmd_wmask(s_cmd_wmask),
        .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready), .s_rsp_rdata(s_rsp_rdata),
        .s_rsp_err(s_rsp_err)
    );

    // Target read data: address tag in the upper half, 0x11 for m0 space and 0x22 for m1 space.
    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        return {a[15:0], 8'h00, a[31:28], a[31:28]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; initiators and the auto target react to last cycle's handshakes.
    task automatic drive_edge();
        @(posedge clk);
        #1;
        if (h0) begin
            m0_cmd_addr += 32'd4;
            if (m0_left > 0) m0_left--;
        end
        if (h1) begin
            m1_cmd_addr += 32'd4;
            if (m1_left > 0) m1_left--;
        end
        if (tgt_auto) begin
            if (hr && pend.size() > 0) void'(pend.pop_front());
            s_rsp_valid = (pend.size() != 0);
            s_rsp_rdata = (pend.size() != 0) ? exp_rd(pend[0]) : '0;
            s_rsp_err   = 1'b0;
        end
    endtask

    // Sample on the falling edge and score any handshakes of this cycle.
    task automatic mon();
        @(negedge clk);
        h0 = m0_cmd_valid & m0_cmd_ready;
        h1 = m1_cmd_valid & m1_cmd_ready;
        hr = s_rsp_valid & s_rsp_ready;
        if (s_cmd_valid && s_cmd_ready) begin
            if (cmd_q.size() == 0) chk("cmd_unexpected", 64'(cmd_q.size()), 64'd1);
            else chk("cmd_addr", 64'(s_cmd_addr), 64'(cmd_q.pop_front()));
            if (tgt_auto) pend.push_back(s_cmd_addr);
        end
        if (m0_rsp_valid && m0_rsp_ready) begin
            if (rsp_q.size() == 0) chk("rsp0_unexpected", 64'(rsp_q.size()), 64'd1);
            else chk("rsp0", 64'({1'b0, m0_rsp_rdata}), 64'(rsp_q.pop_front()));
        end
        if (m1_rsp_valid && m1_rsp_ready) begin
            if (rsp_q.size() == 0) chk("rsp1_unexpected", 64'(rsp_q.size()), 64'd1);
            else chk("rsp1", 64'({1'b1, m1_rsp_rdata}), 64'(rsp_q.pop_front()));
        end
    endtask

    task automatic cyc();
        drive_edge();
        mon();
    endtask

    task automatic drain(input string tag);
        drained = 1'b0;
        for (int i = 0; i < 60 && !drained; i++) begin
            cyc();
            drained = (cmd_q.size() == 0) && (rsp_q.size() == 0) && (pend.size() == 0);
        end
        chk(tag, 64'(drained), 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        m0_left = 1; m1_left = 1;
        m0_cmd_addr = A_BASE; m1_cmd_addr = B_BASE;
        m0_cmd_read = 1'b1; m1_cmd_read = 1'b0;
        m0_cmd_wdata = 32'hA5A5_0000; m1_cmd_wdata = 32'h5A5A_1111;
        m0_cmd_wmask = 4'hF; m1_cmd_wmask = 4'h3;
        m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1;
        s_cmd_ready = 1'b1; s_rsp_valid = 1'b1; s_rsp_rdata = 32'hDEAD_BEEF; s_rsp_err = 1'b0;
        tgt_auto = 1'b0; h0 = 1'b0; h1 = 1'b0; hr = 1'b0;

        // Reset with both requests held
        cyc(); cyc(); cyc();
        chk("rst_s_cmd_valid", 64'(s_cmd_valid), 64'd0);
        chk("rst_m0_cmd_ready", 64'(m0_cmd_ready), 64'd0);
        chk("rst_m1_cmd_ready", 64'(m1_cmd_ready), 64'd0);
        chk("rst_m0_rsp_valid", 64'(m0_rsp_valid), 64'd0);
        chk("rst_m1_rsp_valid", 64'(m1_rsp_valid), 64'd0);
        chk("rst_s_rsp_ready", 64'(s_rsp_ready), 64'd0);

        drive_edge(); rst = 1'b0; s_cmd_ready = 1'b0; s_rsp_valid = 1'b0; mon();
        chk("first_grant_vld", 64'(s_cmd_valid), 64'd1);
        chk("first_grant_addr", 64'(s_cmd_addr), 64'(A_BASE));
        chk("first_grant_read", 64'(s_cmd_read), 64'd1);

        // Both initiators streaming: grants alternate, responses routed by ID
        drive_edge();
        s_cmd_ready = 1'b1; m0_left = 4; m1_left = 4; tgt_auto = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_q.push_back(m0_cmd_addr + 32'(4 * i));
            cmd_q.push_back(m1_cmd_addr + 32'(4 * i));
            rsp_q.push_back({1'b0, exp_rd(m0_cmd_addr + 32'(4 * i))});
            rsp_q.push_back({1'b1, exp_rd(m1_cmd_addr + 32'(4 * i))});
        end
        mon();
        drain("alt_drain");

        // Grant stays on m1 through target wait states
        drive_edge(); s_cmd_ready = 1'b0; m1_left = 1; mon();
        chk("lock_vld", 64'(s_cmd_valid), 64'd1);
        chk("lock_addr0", 64'(s_cmd_addr), 64'(m1_cmd_addr));
        for (int i = 0; i < 2; i++) begin
            drive_edge(); m0_left = 1; mon();
            chk("lock_addr", 64'(s_cmd_addr), 64'(m1_cmd_addr));
            chk("lock_wdata", 64'(s_cmd_wdata), 64'h5A5A_1111);
            chk("lock_m0_rdy", 64'(m0_cmd_ready), 64'd0);
        end
        drive_edge();
        s_cmd_ready = 1'b1;
        cmd_q.push_back(m1_cmd_addr); cmd_q.push_back(m0_cmd_addr);
        rsp_q.push_back({1'b1, exp_rd(m1_cmd_addr)}); rsp_q.push_back({1'b0, exp_rd(m0_cmd_addr)});
        mon();
        chk("lock_wmask", 64'(s_cmd_wmask), 64'h3);
        drive_edge(); mon();
        chk("after_lock_addr", 64'(s_cmd_addr), 64'(m0_cmd_addr));
        chk("after_lock_m0_rdy", 64'(m0_cmd_ready), 64'd1);
        drain("lock_drain");

        // Outstanding limit: third command waits until a pop, then issues the cycle after
        tgt_auto = 1'b0;
        drive_edge();
        m0_left = 3;
        cmd_q.push_back(m0_cmd_addr); cmd_q.push_back(m0_cmd_addr + 32'd4);
        mon();
        cyc();
        cyc();
        chk("full_blk_vld", 64'(s_cmd_valid), 64'd0);
        chk("full_blk_rdy", 64'(m0_cmd_ready), 64'd0);
        cyc();
        chk("full_hold", 64'(s_cmd_valid), 64'd0);
        drive_edge();
        s_rsp_valid = 1'b1; s_rsp_rdata = 32'h0000_0C01; s_rsp_err = 1'b1;
        rsp_q.push_back({1'b0, 32'h0000_0C01});
        mon();
        chk("full_pop_rdy", 64'(s_rsp_ready), 64'd1);
        chk("full_no_bypass", 64'(s_cmd_valid), 64'd0);
        chk("rsp_err", 64'(m0_rsp_err), 64'd1);
        drive_edge();
        s_rsp_valid = 1'b0; s_rsp_err = 1'b0;
        cmd_q.push_back(m0_cmd_addr);
        mon();
        chk("full_resume", 64'(s_cmd_valid), 64'd1);
        chk("full_resume_addr", 64'(s_cmd_addr), 64'(m0_cmd_addr));

        // Initiator response backpressure with m0 at the head and m1 behind it
        drive_edge();
        s_rsp_valid = 1'b1; s_rsp_rdata = 32'h0000_0C02;
        rsp_q.push_back({1'b0, 32'h0000_0C02});
        m1_left = 1;
        mon();
        chk("full_blocks_m1", 64'(s_cmd_valid), 64'd0);
        drive_edge(); s_rsp_valid = 1'b0; cmd_q.push_back(m1_cmd_addr); mon();
        chk("m1_issue", 64'(s_cmd_valid), 64'd1);
        drive_edge(); s_rsp_valid = 1'b1; s_rsp_rdata = 32'h0000_0C03; m0_rsp_ready = 1'b0; mon();
        chk("bp_s_rdy", 64'(s_rsp_ready), 64'd0);
        chk("bp_m1_vld", 64'(m1_rsp_valid), 64'd0);
        chk("bp_m0_vld", 64'(m0_rsp_valid), 64'd1);
        chk("bp_bcast", 64'(m1_rsp_rdata), 64'h0000_0C03);
        cyc();
        chk("bp_hold", 64'(s_rsp_ready), 64'd0);
        drive_edge(); m0_rsp_ready = 1'b1; rsp_q.push_back({1'b0, 32'h0000_0C03}); mon();
        chk("bp_release", 64'(s_rsp_ready), 64'd1);
        drive_edge(); s_rsp_rdata = 32'h0000_0C04; rsp_q.push_back({1'b1, 32'h0000_0C04}); mon();
        chk("bp_m1_route", 64'(m1_rsp_valid), 64'd1);
        chk("bp_m0_quiet", 64'(m0_rsp_valid), 64'd0);
        drive_edge(); s_rsp_valid = 1'b0; mon();
        chk("bp_rsp_drained", 64'(rsp_q.size()), 64'd0);

        // Stray response with nothing outstanding
        drive_edge(); s_rsp_valid = 1'b1; s_rsp_rdata = 32'hDEAD_0000; mon();
        chk("stray_rdy", 64'(s_rsp_ready), 64'd0);
        chk("stray_v0", 64'(m0_rsp_valid), 64'd0);
        chk("stray_v1", 64'(m1_rsp_valid), 64'd0);

        // Reset with two outstanding (m1 then m0, leaving priority on m1)
        drive_edge(); s_rsp_valid = 1'b0; m1_left = 1; cmd_q.push_back(m1_cmd_addr); mon();
        drive_edge(); m0_left = 1; cmd_q.push_back(m0_cmd_addr); mon();
        drive_edge(); rst = 1'b1; s_rsp_valid = 1'b1; s_rsp_rdata = 32'h0000_BAD0; mon();
        chk("rst_mid_rdy", 64'(s_rsp_ready), 64'd0);
        chk("rst_mid_v1", 64'(m1_rsp_valid), 64'd0);
        cyc();
        drive_edge(); rst = 1'b0; m0_left = 1; m1_left = 1; s_cmd_ready = 1'b0; mon();
        chk("post_rst_rsp_rdy", 64'(s_rsp_ready), 64'd0);
        chk("post_rst_v1", 64'(m1_rsp_valid), 64'd0);
        chk("post_rst_vld", 64'(s_cmd_valid), 64'd1);
        chk("post_rst_prio", 64'(s_cmd_addr), 64'(m0_cmd_addr));
        drive_edge();
        s_rsp_valid = 1'b0; s_cmd_ready = 1'b1;
        cmd_q.push_back(m0_cmd_addr); cmd_q.push_back(m1_cmd_addr);
        mon();
        cyc();
        cyc();
        chk("final_cmd_drain", 64'(cmd_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
